multicycle_controlunit: RTL and testbench
=========================================

Name: multicycle_controlunit

Overview:
Parametrised multi-cycle successor to the combinational instruction decoder. It accepts one instruction per valid/ready handshake and decodes it into opcode, three register addresses and an immediate. It executes the instruction against an internal register file, updates a 4-bit flag register, and can drive a data output. It is the sequential core of the processor: the fetch logic feeds it and external I/O observes its outputs.

Parameters:
DATA_W, 8, datapath, immediate and register width.
REG_AW, 5, register address width; the register file holds 2**REG_AW words.
ZERO_REG, 1, when 1 register 0 always reads 0 and writes to it are discarded.
INSTR_W (localparam), 4+3*REG_AW+DATA_W, instruction width; 27 at defaults.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  core can accept an instruction
instr  in  INSTR_W  fields from MSB down: opcode[4], addr1[REG_AW], addr2[REG_AW], addr3[REG_AW], number[DATA_W]
opcode  out  4  latched opcode
addr1  out  REG_AW  latched destination address
addr2  out  REG_AW  latched source A address
addr3  out  REG_AW  latched source B address
number  out  DATA_W  latched immediate
theflag  out  4  {V,N,C,Z}: bit3=V, bit2=N, bit1=C, bit0=Z
output1  out  DATA_W  last OUT value
out_valid  out  1  1-cycle pulse when output1 updates
done  out  1  1-cycle pulse at instruction retire
halted  out  1  HALT executed
illegal  out  1  sticky; set by opcode 15

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset values: all outputs 0 except instr_ready=1; FSM goes to IDLE; all registers are cleared to 0.
- Reset mid-operation: reset in any state aborts the in-flight instruction; no register write or flag update occurs.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE; HALT is terminal.
- IDLE: instr_ready=1. When instr_valid is high, latch all decoded fields and go to READ.
- READ, EXEC, WB: instr_ready=0. instr_valid is ignored (no queuing).
- READ: capture operand A=R[addr2] and B=R[addr3]; this read is registered.
- EXEC: compute the result and the next flags.
- WB: write R[addr1] and theflag as applicable, pulse done, return to IDLE.
- HALT state: entered from WB when opcode=14. instr_ready=0, halted=1, done does not pulse again. Only reset exits it.
- Latency: handshake at edge 0; done high in the cycle after edge 3; next instruction accepted at edge 4. Throughput is 1 instruction per 4 cycles.
- Opcodes (all arithmetic is modulo 2**DATA_W):
  - 0 NOP
  - 1 ADD: R1=A+B
  - 2 SUB: R1=A-B
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOT: R1=~A
  - 7 SHL: R1=A<<1
  - 8 SHR: R1=A>>1, logical
  - 9 LDI: R1=number
  - 10 ADDI: R1=A+number
  - 11 MOV: R1=A
  - 12 CMP: flags from A-B, no register write
  - 13 OUT: output1=A, out_valid pulses in WB
  - 14 HALT
  - 15 illegal: sets illegal, otherwise behaves as NOP
- Flags:
  - ADD, ADDI: C=carry out of the MSB; V=signed overflow.
  - SUB, CMP: C=borrow (A<B unsigned); V=signed overflow.
  - Z and N are computed from the result.
  - Logic ops, NOT, MOV, LDI: update Z and N only.
  - SHL and SHR: update Z and N; C=the bit shifted out.
  - NOP, OUT, HALT, illegal: flags unchanged.
- Register 0: with ZERO_REG=1, a write with addr1=0 is dropped but flags still update. With ZERO_REG=0, register 0 is an ordinary register.
- Read/write ordering: a write in WB is visible to the next instruction's READ. There is no hazard within one instruction.

Test Plan:
- Reset check: reset for 2 cycles -> instr_ready=1; theflag, output1, done, halted and illegal all 0. Then OUT r5 -> output1=0x00, out_valid pulses once.
- Add overflow: LDI r1,0x7F; LDI r2,0x01; ADD r3=r1+r2; OUT r3 -> output1=0x80, theflag=4'b1100; each done exactly 4 cycles after its handshake.
- Subtract: SUB r4=r2-r2 -> R4=0, theflag=4'b0001. Then SUB r4=r2-r1 with r2=1, r1=0x7F -> R4=0x82, theflag=4'b0110 (N=1, C=1, V=0, Z=0).
- Handshake and register 0: hold instr_valid high for 8 cycles with two different instructions -> exactly one is accepted per IDLE; instr_ready low in READ, EXEC and WB. Then LDI r0,0x55; OUT r0 -> output1=0x00.
- Shifts and illegal opcode: LDI r1,0x81; SHL r2=r1 -> R2=0x02, C=1. SHR r2=r1 -> R2=0x40, C=1. Opcode 15 -> illegal=1, and it stays 1 after a following ADD.
- HALT and reset abort: HALT -> halted=1, instr_ready=0, further instr_valid ignored; reset releases it. Assert reset during EXEC of LDI r1,0xAA -> R1 remains 0 and no done pulse.

Source files
------------

// File: rtl/multicycle_controlunit.sv
// Multi-cycle control unit: accepts one instruction per handshake, then walks
// READ -> EXEC -> WB against an internal register file and flag register.
module multicycle_controlunit #(
  parameter int DATA_W   = 8,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 1,
  localparam int INSTR_W = 4 + 3 * REG_AW + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [REG_AW-1:0]  addr1,
  output logic [REG_AW-1:0]  addr2,
  output logic [REG_AW-1:0]  addr3,
  output logic [DATA_W-1:0]  number,
  output logic [3:0]         theflag,
  output logic [DATA_W-1:0]  output1,
  output logic               out_valid,
  output logic               done,
  output logic               halted,
  output logic               illegal
);

  localparam int MSB      = DATA_W - 1;
  localparam int RF_DEPTH = 1 << REG_AW;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_LDI  = 4'd9;
  localparam logic [3:0] OP_ADDI = 4'd10;
  localparam logic [3:0] OP_MOV  = 4'd11;
  localparam logic [3:0] OP_CMP  = 4'd12;
  localparam logic [3:0] OP_OUT  = 4'd13;
  localparam logic [3:0] OP_HALT = 4'd14;
  localparam logic [3:0] OP_ILL  = 4'd15;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB, S_HALT} state_t;

  state_t state_q, state_d;

  logic [3:0]        opcode_q;
  logic [REG_AW-1:0] addr1_q, addr2_q, addr3_q;
  logic [DATA_W-1:0] number_q;
  logic [DATA_W-1:0] a_q, b_q, res_q, out_q;
  logic [3:0]        flg_q, flags_q;
  logic              wr_q, out_valid_q, done_q, halted_q, illegal_q;
  logic [DATA_W-1:0] rf [RF_DEPTH];

  logic [DATA_W-1:0] rd_a, rd_b, opb, alu_res;
  logic [DATA_W:0]   sum_w, diff_w;
  logic [3:0]        alu_flags;
  logic              new_v, new_c, upd_nz, alu_wr;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_READ;
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = (opcode_q == OP_HALT) ? S_HALT : S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_a = (ZERO_REG != 0 && addr2_q == '0) ? '0 : rf[addr2_q];
  assign rd_b = (ZERO_REG != 0 && addr3_q == '0) ? '0 : rf[addr3_q];

  // ALU; flags not touched by an opcode keep their previous value.
  always_comb begin
    opb     = (opcode_q == OP_ADDI) ? number_q : b_q;
    sum_w   = {1'b0, a_q} + {1'b0, opb};
    diff_w  = {1'b0, a_q} - {1'b0, b_q};
    alu_res = '0;
    new_v   = flags_q[3];
    new_c   = flags_q[1];
    upd_nz  = 1'b1;
    alu_wr  = 1'b1;
    case (opcode_q)
      OP_ADD, OP_ADDI: begin
        alu_res = sum_w[MSB:0];
        new_c   = sum_w[DATA_W];
        new_v   = (a_q[MSB] == opb[MSB]) && (sum_w[MSB] != a_q[MSB]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff_w[MSB:0];
        new_c   = diff_w[DATA_W];
        new_v   = (a_q[MSB] != b_q[MSB]) && (diff_w[MSB] != a_q[MSB]);
        alu_wr  = (opcode_q == OP_SUB);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SHL: begin
        alu_res = {a_q[MSB-1:0], 1'b0};
        new_c   = a_q[MSB];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_q[MSB:1]};
        new_c   = a_q[0];
      end
      OP_LDI: alu_res = number_q;
      OP_MOV: alu_res = a_q;
      default: begin
        upd_nz = 1'b0;
        alu_wr = 1'b0;
      end
    endcase
    alu_flags = upd_nz ? {new_v, alu_res[MSB], new_c, (alu_res == '0)} : flags_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q    <= '0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      addr3_q     <= '0;
      number_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      flg_q       <= '0;
      wr_q        <= 1'b0;
      flags_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      // NOTE: the register file is cleared on reset, so it maps to flops, not RAM.
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else begin
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            opcode_q <= instr[INSTR_W-1 -: 4];
            addr1_q  <= instr[INSTR_W-5 -: REG_AW];
            addr2_q  <= instr[INSTR_W-5-REG_AW -: REG_AW];
            addr3_q  <= instr[DATA_W+REG_AW-1 -: REG_AW];
            number_q <= instr[DATA_W-1:0];
          end
        end
        S_READ: begin
          a_q <= rd_a;
          b_q <= rd_b;
        end
        S_EXEC: begin
          res_q <= alu_res;
          flg_q <= alu_flags;
          wr_q  <= alu_wr;
        end
        S_WB: begin
          if (wr_q && !(ZERO_REG != 0 && addr1_q == '0)) rf[addr1_q] <= res_q;
          flags_q <= flg_q;
          done_q  <= 1'b1;
          if (opcode_q == OP_OUT) begin
            out_q       <= a_q;
            out_valid_q <= 1'b1;
          end
          if (opcode_q == OP_ILL)  illegal_q <= 1'b1;
          if (opcode_q == OP_HALT) halted_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign opcode    = opcode_q;
  assign addr1     = addr1_q;
  assign addr2     = addr2_q;
  assign addr3     = addr3_q;
  assign number    = number_q;
  assign theflag   = flags_q;
  assign output1   = out_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Scoreboard bench for multicycle_controlunit at default parameters.
module tb_multicycle_controlunit;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [26:0] instr;
  logic [3:0]  opcode;
  logic [4:0]  addr1, addr2, addr3;
  logic [7:0]  number;
  logic [3:0]  theflag;
  logic [7:0]  output1;
  logic        out_valid, done, halted, illegal;

  multicycle_controlunit dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .opcode(opcode), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .number(number), .theflag(theflag), .output1(output1), .out_valid(out_valid),
    .done(done), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] flags;
    bit         is_out;
    logic [7:0] out_val;
    bit         ill;
    bit         halt;
  } exp_t;

  exp_t       sb_q[$];
  int         rf_m[32];
  logic [3:0] flags_m;
  bit         ill_m;

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rf_m[i] = 0;
    flags_m = 4'b0000;
    ill_m   = 1'b0;
    sb_q.delete();
  endtask

  // Reference model: computes expected outcome and pushes it to the scoreboard.
  task automatic model_push(input logic [3:0] op, input int a1, input int a2, input int a3, input int num);
    exp_t e;
    int a, b, r, s;
    bit v, c, upd, wr;
    a = rf_m[a2]; b = rf_m[a3]; r = 0; s = 0;
    v = flags_m[3]; c = flags_m[1]; upd = 1'b1; wr = 1'b1;
    e.is_out = 1'b0; e.out_val = 8'h00; e.halt = 1'b0;
    case (op)
      4'd1:  begin r = a + b;   c = (r > 255); s = sx(a) + sx(b);   v = (s > 127) || (s < -128); end
      4'd10: begin r = a + num; c = (r > 255); s = sx(a) + sx(num); v = (s > 127) || (s < -128); end
      4'd2, 4'd12: begin
        r = a - b; c = (a < b); s = sx(a) - sx(b); v = (s > 127) || (s < -128);
        wr = (op == 4'd2);
      end
      4'd3:  r = a & b;
      4'd4:  r = a | b;
      4'd5:  r = a ^ b;
      4'd6:  r = 255 - a;
      4'd7:  begin r = a * 2; c = (a >= 128); end
      4'd8:  begin r = a / 2; c = (a % 2 == 1); end
      4'd9:  r = num;
      4'd11: r = a;
      default: begin
        upd = 1'b0; wr = 1'b0;
        if (op == 4'd13) begin e.is_out = 1'b1; e.out_val = a[7:0]; end
        if (op == 4'd14) e.halt = 1'b1;
        if (op == 4'd15) ill_m = 1'b1;
      end
    endcase
    r = r & 255;
    if (upd) flags_m = {v, (r >= 128), c, (r == 0)};
    if (wr && a1 != 0) rf_m[a1] = r;
    e.flags = flags_m;
    e.ill   = ill_m;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Drive one instruction, wait for retire, then pop and compare.
  task automatic send(input logic [3:0] op, input int a1, input int a2, input int a3, input int num);
    exp_t e;
    int n;
    bit seen;
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout op=%0d ready=%0b required=1", op, instr_ready);
      return;
    end
    instr = {op, a1[4:0], a2[4:0], a3[4:0], num[7:0]};
    instr_valid = 1'b1;
    model_push(op, a1, a2, a3, num);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    n = 0; seen = 1'b0;
    repeat (8) begin
      @(negedge clk); n++;
      if (done) begin seen = 1'b1; break; end
    end
    e = sb_q.pop_front();
    checks++;
    if (!seen || n != 4) begin failures++; $display("FAIL latency op=%0d got=%0d required=4 seen=%0b", op, n, seen); end
    checks++;
    if (theflag !== e.flags) begin failures++; $display("FAIL flags op=%0d got=%b required=%b", op, theflag, e.flags); end
    checks++;
    if (out_valid !== e.is_out) begin failures++; $display("FAIL out_valid op=%0d got=%b required=%b", op, out_valid, e.is_out); end
    if (e.is_out) begin
      checks++;
      if (output1 !== e.out_val) begin failures++; $display("FAIL output1 op=%0d got=%h required=%h", op, output1, e.out_val); end
    end
    checks++;
    if (illegal !== e.ill) begin failures++; $display("FAIL illegal op=%0d got=%b required=%b", op, illegal, e.ill); end
    checks++;
    if (halted !== e.halt || instr_ready !== !e.halt) begin
      failures++;
      $display("FAIL halt_state op=%0d halted=%b ready=%b required_halted=%b", op, halted, instr_ready, e.halt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b required=1", instr_ready); end
    checks++; if (theflag !== 4'h0) begin failures++; $display("FAIL rst_flag got=%b required=0000", theflag); end
    checks++; if (output1 !== 8'h00) begin failures++; $display("FAIL rst_output1 got=%h required=00", output1); end
    checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_pulses done=%b out_valid=%b required=0", done, out_valid); end
    checks++; if (halted !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL rst_sticky halted=%b illegal=%b required=0", halted, illegal); end
    send(4'd13, 0, 5, 0, 0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL out_valid_single got=%b required=0", out_valid); end
  endtask

  task automatic test_add_overflow();
    send(4'd9, 1, 0, 0, 8'h7F);
    send(4'd9, 2, 0, 0, 8'h01);
    send(4'd1, 3, 1, 2, 0);
    checks++; if (theflag !== 4'b1100) begin failures++; $display("FAIL add_flags got=%b required=1100", theflag); end
    send(4'd13, 0, 3, 0, 0);
    checks++; if (output1 !== 8'h80) begin failures++; $display("FAIL add_out got=%h required=80", output1); end
  endtask

  task automatic test_sub();
    send(4'd2, 4, 2, 2, 0);
    checks++; if (theflag !== 4'b0001) begin failures++; $display("FAIL sub_zero_flags got=%b required=0001", theflag); end
    send(4'd13, 0, 4, 0, 0);
    send(4'd2, 4, 2, 1, 0);
    checks++; if (theflag !== 4'b0110) begin failures++; $display("FAIL sub_neg_flags got=%b required=0110", theflag); end
    send(4'd13, 0, 4, 0, 0);
    checks++; if (output1 !== 8'h82) begin failures++; $display("FAIL sub_out got=%h required=82", output1); end
  endtask

  task automatic test_handshake();
    exp_t e;
    logic [7:0] ready_seen;
    int dn;
    dn = 0;
    @(negedge clk);
    instr = {4'd10, 5'd6, 5'd6, 5'd0, 8'd1};
    instr_valid = 1'b1;
    model_push(4'd10, 6, 6, 0, 1);
    model_push(4'd10, 7, 7, 0, 2);
    for (int i = 0; i < 8; i++) begin
      ready_seen[7-i] = instr_ready;
      if (i == 1) instr = {4'd10, 5'd7, 5'd7, 5'd0, 8'd2};
      if (done) begin
        dn++;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          checks++;
          if (theflag !== e.flags) begin failures++; $display("FAIL hs_flags got=%b required=%b", theflag, e.flags); end
        end
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    if (done) begin
      dn++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (theflag !== e.flags) begin failures++; $display("FAIL hs_flags got=%b required=%b", theflag, e.flags); end
      end
    end
    checks++; if (ready_seen !== 8'b1000_1000) begin failures++; $display("FAIL hs_ready got=%b required=10001000", ready_seen); end
    checks++; if (dn != 2) begin failures++; $display("FAIL hs_done_count got=%0d required=2", dn); end
    sb_q.delete();
    send(4'd13, 0, 6, 0, 0);
    checks++; if (output1 !== 8'h01) begin failures++; $display("FAIL hs_single_accept got=%h required=01", output1); end
    send(4'd13, 0, 7, 0, 0);
    send(4'd9, 0, 0, 0, 8'h55);
    send(4'd13, 0, 0, 0, 0);
    checks++; if (output1 !== 8'h00) begin failures++; $display("FAIL r0_write got=%h required=00", output1); end
  endtask

  task automatic test_shift_illegal();
    send(4'd9, 1, 0, 0, 8'h81);
    send(4'd7, 2, 1, 0, 0);
    checks++; if (theflag[1] !== 1'b1) begin failures++; $display("FAIL shl_carry got=%b required=1", theflag[1]); end
    send(4'd13, 0, 2, 0, 0);
    checks++; if (output1 !== 8'h02) begin failures++; $display("FAIL shl_out got=%h required=02", output1); end
    send(4'd8, 2, 1, 0, 0);
    checks++; if (theflag[1] !== 1'b1) begin failures++; $display("FAIL shr_carry got=%b required=1", theflag[1]); end
    send(4'd13, 0, 2, 0, 0);
    checks++; if (output1 !== 8'h40) begin failures++; $display("FAIL shr_out got=%h required=40", output1); end
    send(4'd15, 0, 0, 0, 0);
    send(4'd1, 3, 1, 2, 0);
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL illegal_sticky got=%b required=1", illegal); end
  endtask

  task automatic test_halt();
    bit bad;
    send(4'd14, 0, 0, 0, 0);
    bad = 1'b0;
    instr = {4'd9, 5'd1, 5'd0, 5'd0, 8'h33};
    instr_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (instr_ready !== 1'b0 || done !== 1'b0 || halted !== 1'b1) bad = 1'b1;
    end
    instr_valid = 1'b0;
    checks++; if (bad) begin failures++; $display("FAIL halt_hold ready=%b done=%b halted=%b required=0/0/1", instr_ready, done, halted); end
    do_reset();
    checks++; if (halted !== 1'b0 || instr_ready !== 1'b1) begin failures++; $display("FAIL halt_release halted=%b ready=%b required=0/1", halted, instr_ready); end
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    instr = {4'd9, 5'd1, 5'd0, 5'd0, 8'hAA};
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    if (done) saw_done = 1'b1;
    @(negedge clk);
    if (done) saw_done = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (5) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin failures++; $display("FAIL abort_done got=1 required=0"); end
    send(4'd13, 0, 1, 0, 0);
    checks++; if (output1 !== 8'h00) begin failures++; $display("FAIL abort_r1 got=%h required=00", output1); end
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    model_reset();
    test_reset();
    test_add_overflow();
    test_sub();
    test_handshake();
    test_shift_illegal();
    test_halt();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
